dff_en_share_arb: RTL and testbench
===================================

Name: dff_en_share_arb

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit enabled register.
- The register behaves as a D flip-flop with enable: it captures only when the arbiter fires its internal enable, otherwise it holds.
- Four requesters compete for write access to the register.
- The block selects one winner per write, loads its data, acknowledges it, then enforces a programmable quiet gap before the next write.

Parameters:
- WIDTH, 8: data width of the shared register and of each requester data port.
- GAP, 2: idle cycles forced after each write before new requests are arbitrated. Legal range 0..15. A value of 0 allows a write on every cycle.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- en  input  1  global enable. When 0, no new grant is issued and q holds.
- req  input  4  request per requester. Bit i is held high until ack[i].
- d0  input  WIDTH  data from requester 0
- d1  input  WIDTH  data from requester 1
- d2  input  WIDTH  data from requester 2
- d3  input  WIDTH  data from requester 3
- q  output  WIDTH  shared register contents
- ack  output  4  one-hot, one-cycle pulse. Marks the requester whose data was written at the preceding edge.
- grant_id  output  2  index of the last requester written
- valid  output  1  high once q has been written at least once since reset
- busy  output  1  high while in GAP state

Behaviour:
- Reset (reset_n low, asynchronous): all of the following take effect immediately, without waiting for clk.
  - q=0, ack=0, grant_id=0, valid=0, busy=0.
  - Priority pointer ptr=0, gap counter=0, state=IDLE.
  - Reset asserted mid-GAP aborts the gap. Reset asserted during an ack cycle clears ack immediately.
- States: IDLE, GAP.
- IDLE, on a clock edge with en=1 and req!=0:
  - Winner = first set bit of req, searching ptr, ptr+1, ... modulo 4.
  - q <= d[winner].
  - ack <= one-hot(winner) for exactly one cycle.
  - grant_id <= winner.
  - valid <= 1.
  - ptr <= (winner+1) mod 4.
  - If GAP>0: counter <= GAP-1 and state -> GAP. If GAP=0: stay in IDLE.
- IDLE, with en=0 or req=0: no write, ack=0, q/grant_id/ptr unchanged.
- GAP:
  - busy=1. req is ignored and ack=0.
  - Counter decrements each edge. At counter==0 the next edge returns to IDLE.
  - Total GAP length is exactly GAP cycles.
  - en has no effect on counting.
- Latency: the edge that samples a winning req also updates q. ack is visible in the following cycle, aligned with the new q.
- Requester rule: deassert req[i] in the cycle ack[i] is high. With GAP=0, a req still high in the ack cycle is treated as a fresh request, arbitrated under the already-advanced ptr.
- Fairness: no requester is granted twice while another requester is continuously requesting. Worst-case wait is 3 writes.
- Data mux is combinational from d0..d3, sampled only at the write edge. q never changes except on a write or reset.
- en dropped while req is pending: the request waits, with no loss and no ack, until en returns high.

Test Plan:
- Reset and idle:
  - Stimulus: assert reset_n=0 mid-cycle, then release; hold req=0.
  - Required: q=0, ack=0, valid=0, busy=0 immediately on reset, and they stay so for 10 cycles after release.
- Single request, WIDTH=8, GAP=2:
  - Stimulus: req=0001, d0=8'hA5; drop req on ack.
  - Required: q=8'hA5, grant_id=0, ack=0001 for one cycle, valid=1.
  - Required: busy=1 for exactly 2 cycles, then busy=0.
- Round-robin order:
  - Stimulus: req=1111 held, each bit dropped on its ack, d0..d3 = 11, 22, 33, 44, GAP=0.
  - Required: writes on consecutive edges in order 0,1,2,3, with q sequence 11, 22, 33, 44.
  - Stimulus: then raise req=1001.
  - Required: requester 0 wins (ptr=0), then requester 3.
- Gap masking:
  - Stimulus: GAP=2; raise req=0100 during the GAP cycles after a write by requester 1.
  - Required: no ack during GAP. Requester 2 is written on the first IDLE edge.
- Enable hold:
  - Stimulus: en=0 with req=0010, d1=8'h3C, for 5 cycles.
  - Required: q unchanged, ack=0.
  - Stimulus: then en=1.
  - Required: q=8'h3C and ack=0010 one cycle later.
- Reset mid-operation:
  - Stimulus: assert reset_n low during GAP and during an ack cycle.
  - Required: state IDLE, q=0, ack=0, ptr=0. After release, req=1000 gives grant_id=3.

Source files
------------

// File: rtl/dff_en_share_arb.sv
// Round-robin arbiter that writes one of four requesters into a shared enabled register.
// Latency: the winning edge loads q; ack/grant_id appear with the new q in the next cycle.
// Backpressure: requesters hold req until ack; en=0 or a GAP window defers grants without loss.
module dff_en_share_arb #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] q,
  output logic [3:0]       ack,
  output logic [1:0]       grant_id,
  output logic             valid,
  output logic             busy
);

  typedef enum logic {ST_IDLE, ST_GAP} state_t;

  // Counter preload: GAP-1 so that the quiet window lasts exactly GAP cycles.
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t           state;
  logic [1:0]       ptr;
  logic [3:0]       gap_cnt;
  logic [1:0]       win;
  logic             win_vld;
  logic [1:0]       cand;
  logic [WIDTH-1:0] win_dat;

  // Rotating priority search: first set req bit starting at ptr, wrapping modulo 4.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    cand    = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Data mux for the selected requester; only sampled on a write edge.
  always_comb begin
    case (win)
      2'd0:    win_dat = d0;
      2'd1:    win_dat = d1;
      2'd2:    win_dat = d2;
      default: win_dat = d3;
    endcase
  end

  // Sequencer: grant and load in IDLE, then count out the quiet window in GAP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ptr      <= 2'd0;
      gap_cnt  <= 4'd0;
      q        <= '0;
      ack      <= 4'd0;
      grant_id <= 2'd0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ack <= 4'd0;
      case (state)
        ST_IDLE: begin
          if (en && win_vld) begin
            q        <= win_dat;
            ack      <= 4'b0001 << win;
            grant_id <= win;
            valid    <= 1'b1;
            ptr      <= win + 2'd1;
            if (GAP > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
              busy    <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_en_share_arb.sv
module tb_dff_en_share_arb;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       en = 1'b0;
  logic [3:0] req_a = 4'd0;
  logic [3:0] req_b = 4'd0;
  logic [7:0] d0 = 8'd0, d1 = 8'd0, d2 = 8'd0, d3 = 8'd0;

  logic [7:0] q_a, q_b;
  logic [3:0] ack_a, ack_b;
  logic [1:0] gid_a, gid_b;
  logic       valid_a, valid_b, busy_a, busy_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, index 0 = GAP=2 instance, index 1 = GAP=0 instance.
  logic [7:0] m_q     [2];
  logic [3:0] m_ack   [2];
  logic [1:0] m_gid   [2];
  logic       m_valid [2];
  logic       m_busy  [2];
  int         m_ptr   [2];
  int         m_left  [2];

  always #5 clk = ~clk;

  dff_en_share_arb #(.WIDTH(8), .GAP(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .req(req_a),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .q(q_a), .ack(ack_a), .grant_id(gid_a), .valid(valid_a), .busy(busy_a)
  );

  dff_en_share_arb #(.WIDTH(8), .GAP(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .req(req_b),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .q(q_b), .ack(ack_b), .grant_id(gid_b), .valid(valid_b), .busy(busy_b)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_q[m] = 8'd0; m_ack[m] = 4'd0; m_gid[m] = 2'd0;
      m_valid[m] = 1'b0; m_busy[m] = 1'b0; m_ptr[m] = 0; m_left[m] = 0;
    end
  endtask

  // One clock edge of the specified behaviour: remaining-gap count, rotating priority.
  task automatic model_step(input int m, input int gapv, input logic [3:0] r);
    logic [7:0] dv [4];
    int i;
    dv = '{d0, d1, d2, d3};
    m_ack[m] = 4'd0;
    if (m_left[m] > 0) begin
      m_left[m] = m_left[m] - 1;
    end else if (en && r != 4'd0) begin
      for (int off = 0; off < 4; off++) begin
        i = (m_ptr[m] + off) % 4;
        if (r[i]) begin
          m_q[m]     = dv[i];
          m_ack[m]   = 4'(1 << i);
          m_gid[m]   = 2'(i);
          m_valid[m] = 1'b1;
          m_ptr[m]   = (i + 1) % 4;
          m_left[m]  = gapv;
          break;
        end
      end
    end
    m_busy[m] = (m_left[m] > 0);
  endtask

  // Advance one cycle: model sees the inputs present at the edge, outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    model_step(0, 2, req_a);
    model_step(1, 0, req_b);
    @(negedge clk);
  endtask

  task automatic assert_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    assert_reset();
    vectors++;
    if ({q_a, ack_a, valid_a, busy_a, gid_a} !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_immediate: got q=%h ack=%b valid=%b busy=%b gid=%0d, required all zero", q_a, ack_a, valid_a, busy_a, gid_a);
    end
    release_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if ({q_a, ack_a, valid_a, busy_a, q_b, ack_b, valid_b, busy_b} !== 28'd0) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: got q=%h ack=%b valid=%b busy=%b, required zero", c, q_a, ack_a, valid_a, busy_a);
      end
    end
  endtask

  task automatic test_single();
    en = 1'b1; req_a = 4'b0001; d0 = 8'hA5;
    tick();
    vectors++;
    if ({q_a, gid_a, ack_a, valid_a, busy_a} !== {8'hA5, 2'd0, 4'b0001, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL single_write: got q=%h gid=%0d ack=%b valid=%b busy=%b, required q=a5 gid=0 ack=0001 valid=1 busy=1", q_a, gid_a, ack_a, valid_a, busy_a);
    end
    req_a = 4'd0;
    tick();
    vectors++;
    if ({ack_a, busy_a} !== {4'b0000, 1'b1}) begin
      miscompares++;
      $display("FAIL single_gap1: got ack=%b busy=%b, required ack=0000 busy=1", ack_a, busy_a);
    end
    tick();
    vectors++;
    if ({ack_a, busy_a, q_a} !== {4'b0000, 1'b0, 8'hA5}) begin
      miscompares++;
      $display("FAIL single_gap_end: got ack=%b busy=%b q=%h, required ack=0000 busy=0 q=a5", ack_a, busy_a, q_a);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] rr_exp [4];
    rr_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    d0 = 8'h11; d1 = 8'h22; d2 = 8'h33; d3 = 8'h44;
    req_b = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({ack_b, q_b, gid_b, busy_b} !== {4'(1 << i), rr_exp[i], 2'(i), 1'b0}) begin
        miscompares++;
        $display("FAIL rr_order step %0d: got ack=%b q=%h gid=%0d busy=%b, required ack=%b q=%h gid=%0d busy=0", i, ack_b, q_b, gid_b, busy_b, 4'(1 << i), rr_exp[i], i);
      end
      req_b[i] = 1'b0;
    end
    req_b = 4'b1001;
    tick();
    vectors++;
    if ({gid_b, ack_b, q_b} !== {2'd0, 4'b0001, 8'h11}) begin
      miscompares++;
      $display("FAIL rr_wrap_first: got gid=%0d ack=%b q=%h, required gid=0 ack=0001 q=11", gid_b, ack_b, q_b);
    end
    req_b = 4'b1000;
    tick();
    vectors++;
    if ({gid_b, ack_b, q_b} !== {2'd3, 4'b1000, 8'h44}) begin
      miscompares++;
      $display("FAIL rr_wrap_second: got gid=%0d ack=%b q=%h, required gid=3 ack=1000 q=44", gid_b, ack_b, q_b);
    end
    req_b = 4'd0;
    tick();
  endtask

  task automatic test_gap_masking();
    d1 = 8'h5A; d2 = 8'h77;
    req_a = 4'b0010;
    tick();
    vectors++;
    if ({ack_a, q_a} !== {4'b0010, 8'h5A}) begin
      miscompares++;
      $display("FAIL gap_first_write: got ack=%b q=%h, required ack=0010 q=5a", ack_a, q_a);
    end
    req_a = 4'b0100;
    tick();
    vectors++;
    if ({ack_a, busy_a, q_a} !== {4'b0000, 1'b1, 8'h5A}) begin
      miscompares++;
      $display("FAIL gap_masked1: got ack=%b busy=%b q=%h, required ack=0000 busy=1 q=5a", ack_a, busy_a, q_a);
    end
    tick();
    vectors++;
    if ({ack_a, busy_a, q_a} !== {4'b0000, 1'b0, 8'h5A}) begin
      miscompares++;
      $display("FAIL gap_masked2: got ack=%b busy=%b q=%h, required ack=0000 busy=0 q=5a", ack_a, busy_a, q_a);
    end
    tick();
    vectors++;
    if ({ack_a, gid_a, q_a} !== {4'b0100, 2'd2, 8'h77}) begin
      miscompares++;
      $display("FAIL gap_first_idle_write: got ack=%b gid=%0d q=%h, required ack=0100 gid=2 q=77", ack_a, gid_a, q_a);
    end
    req_a = 4'd0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_enable_hold();
    en = 1'b0; req_a = 4'b0010; d1 = 8'h3C;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if ({q_a, ack_a} !== {8'h77, 4'b0000}) begin
        miscompares++;
        $display("FAIL en_hold cycle %0d: got q=%h ack=%b, required q=77 ack=0000", c, q_a, ack_a);
      end
    end
    en = 1'b1;
    tick();
    vectors++;
    if ({q_a, ack_a, gid_a} !== {8'h3C, 4'b0010, 2'd1}) begin
      miscompares++;
      $display("FAIL en_resume: got q=%h ack=%b gid=%0d, required q=3c ack=0010 gid=1", q_a, ack_a, gid_a);
    end
    req_a = 4'd0;
  endtask

  task automatic test_reset_mid();
    // DUT is currently in the ack cycle of the 3c write.
    assert_reset();
    vectors++;
    if ({q_a, ack_a, valid_a, busy_a, gid_a} !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_in_ack: got q=%h ack=%b valid=%b busy=%b gid=%0d, required all zero", q_a, ack_a, valid_a, busy_a, gid_a);
    end
    release_reset();
    d2 = 8'h99; req_a = 4'b0100;
    tick();
    vectors++;
    if ({ack_a, gid_a} !== {4'b0100, 2'd2}) begin
      miscompares++;
      $display("FAIL post_reset_write: got ack=%b gid=%0d, required ack=0100 gid=2", ack_a, gid_a);
    end
    req_a = 4'd0;
    tick();
    assert_reset();
    vectors++;
    if ({q_a, ack_a, valid_a, busy_a} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_in_gap: got q=%h ack=%b valid=%b busy=%b, required all zero", q_a, ack_a, valid_a, busy_a);
    end
    release_reset();
    // Pointer must be back at 0: requester 2 beats requester 3.
    req_a = 4'b1100;
    tick();
    vectors++;
    if ({gid_a, ack_a, q_a} !== {2'd2, 4'b0100, 8'h99}) begin
      miscompares++;
      $display("FAIL reset_ptr_cleared: got gid=%0d ack=%b q=%h, required gid=2 ack=0100 q=99", gid_a, ack_a, q_a);
    end
    req_a = 4'd0;
    tick();
    tick();
    assert_reset();
    release_reset();
    d3 = 8'hE1; req_a = 4'b1000;
    tick();
    vectors++;
    if ({gid_a, ack_a, q_a, valid_a} !== {2'd3, 4'b1000, 8'hE1, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_then_req3: got gid=%0d ack=%b q=%h valid=%b, required gid=3 ack=1000 q=e1 valid=1", gid_a, ack_a, q_a, valid_a);
    end
    req_a = 4'd0;
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en    = ($urandom_range(0, 7) != 0);
      req_a = 4'($urandom_range(0, 15));
      req_b = 4'($urandom_range(0, 15));
      d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
      tick();
      vectors++;
      if ({q_a, ack_a, gid_a, valid_a, busy_a} !== {m_q[0], m_ack[0], m_gid[0], m_valid[0], m_busy[0]}) begin
        miscompares++;
        $display("FAIL random_gap2 cycle %0d: got q=%h ack=%b gid=%0d valid=%b busy=%b, required q=%h ack=%b gid=%0d valid=%b busy=%b",
                 c, q_a, ack_a, gid_a, valid_a, busy_a, m_q[0], m_ack[0], m_gid[0], m_valid[0], m_busy[0]);
      end
      vectors++;
      if ({q_b, ack_b, gid_b, valid_b, busy_b} !== {m_q[1], m_ack[1], m_gid[1], m_valid[1], m_busy[1]}) begin
        miscompares++;
        $display("FAIL random_gap0 cycle %0d: got q=%h ack=%b gid=%0d valid=%b busy=%b, required q=%h ack=%b gid=%0d valid=%b busy=%b",
                 c, q_b, ack_b, gid_b, valid_b, busy_b, m_q[1], m_ack[1], m_gid[1], m_valid[1], m_busy[1]);
      end
    end
    req_a = 4'd0;
    req_b = 4'd0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_gap_masking();
    test_enable_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
